// File: rtl/kpn_fifo_channel.sv
// kpn_fifo_channel: parametrised KPN channel FIFO with valid/ready ports, reset-time token preload,
// occupancy count and sticky overflow/underflow flags.
module kpn_fifo_channel #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 5,
    parameter int PRELOAD_COUNT = 4,
    parameter int PRELOAD_BASE  = 0,
    parameter int PRELOAD_STEP  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_ready,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow_err,
    output logic                  underflow_err,
    input  logic                  clear_err
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_C   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   PRE_CNT   = (ADDR_WIDTH+1)'(PRELOAD_COUNT);
    localparam logic [ADDR_WIDTH-1:0] PRE_WPTR  = ADDR_WIDTH'(PRELOAD_COUNT % DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_rd_ptr, r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_ovf, r_udf;
    logic                  w_wr_en, w_rd_en;

    function automatic logic [DATA_WIDTH-1:0] preload_val(input int k);
        return DATA_WIDTH'(PRELOAD_BASE + k * PRELOAD_STEP);
    endfunction

    // full/empty come from the count so a full ring never looks empty
    assign full          = r_count == DEPTH_C;
    assign empty         = r_count == '0;
    assign wr_ready      = !full;
    assign rd_valid      = !empty;
    assign rd_data       = r_mem[r_rd_ptr];
    assign count         = r_count;
    assign overflow_err  = r_ovf;
    assign underflow_err = r_udf;
    assign w_wr_en       = wr_valid && !full;
    assign w_rd_en       = rd_ready && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++)
                r_mem[k] <= (k < PRELOAD_COUNT) ? preload_val(k) : '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= PRE_WPTR;
            r_count  <= PRE_CNT;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_wr_en)
                r_mem[r_wr_ptr] <= wr_data;
            r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(w_wr_en);
            r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(w_rd_en);
            r_count  <= r_count + (ADDR_WIDTH+1)'(w_wr_en) - (ADDR_WIDTH+1)'(w_rd_en);
            // a new error event at the same edge as clear_err wins
            r_ovf    <= (r_ovf && !clear_err) || (wr_valid && full);
            r_udf    <= (r_udf && !clear_err) || (rd_ready && empty);
        end
    end
endmodule

// File: tb/tb_kpn_fifo_channel.sv
// tb_kpn_fifo_channel: randomized and directed checks of kpn_fifo_channel against a queue-based model;
// a second instance with PRELOAD_COUNT=0 covers the empty-start latency case.
module tb_kpn_fifo_channel;
    localparam int DEPTH = 32;

    logic        clk = 0;
    logic        reset = 1;
    logic        wr_valid = 0, rd_ready = 0, clear_err = 0;
    logic [15:0] wr_data = 0;
    logic        wr_ready, rd_valid, full, empty, overflow_err, underflow_err;
    logic [15:0] rd_data;
    logic [5:0]  count;

    logic        wv0 = 0, rr0 = 0;
    logic [15:0] wd0 = 0;
    logic        wr_ready0, rd_valid0, full0, empty0, ovf0, udf0;
    logic [15:0] rd_data0;
    logic [5:0]  count0;

    int errors = 0;
    int checks = 0;

    logic [15:0] m_q[$];
    logic        m_ovf, m_udf;

    always #5 clk = ~clk;

    kpn_fifo_channel dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready), .count(count), .full(full),
        .empty(empty), .overflow_err(overflow_err), .underflow_err(underflow_err), .clear_err(clear_err)
    );

    kpn_fifo_channel #(.PRELOAD_COUNT(0)) dut0 (
        .clk(clk), .reset(reset), .wr_valid(wv0), .wr_data(wd0), .wr_ready(wr_ready0),
        .rd_valid(rd_valid0), .rd_data(rd_data0), .rd_ready(rr0), .count(count0), .full(full0),
        .empty(empty0), .overflow_err(ovf0), .underflow_err(udf0), .clear_err(1'b0)
    );

    task automatic model_reset();
        m_q = {};
        for (int k = 0; k < 4; k++) m_q.push_back(16'(k));
        m_ovf = 0;
        m_udf = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        wr_valid = 0; rd_ready = 0; clear_err = 0; wv0 = 0; rr0 = 0;
        reset = 1;
        model_reset();
        #2;
        @(negedge clk);
        reset = 0;
    endtask

    // drive one cycle and advance the model by the rules of the channel
    task automatic step(input logic wv, input logic [15:0] wd, input logic rr, input logic clr);
        bit f, e;
        wr_valid = wv; wr_data = wd; rd_ready = rr; clear_err = clr;
        @(posedge clk);
        f = m_q.size() == DEPTH;
        e = m_q.size() == 0;
        m_ovf = (m_ovf && !clr) || (wv && f);
        m_udf = (m_udf && !clr) || (rr && e);
        if (rr && !e) void'(m_q.pop_front());
        if (wv && !f) m_q.push_back(wd);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (count !== 6'd4) begin errors++; $display("FAIL reset_count got=%0d exp=4", count); end
        checks++; if (rd_data !== 16'd0) begin errors++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
        checks++; if ({full, empty, wr_ready, rd_valid} !== 4'b0011) begin errors++; $display("FAIL reset_status got=%b exp=0011", {full, empty, wr_ready, rd_valid}); end
        checks++; if ({overflow_err, underflow_err} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {overflow_err, underflow_err}); end
        checks++; if ({count0, empty0, full0, rd_valid0} !== {6'd0, 3'b100}) begin errors++; $display("FAIL reset0 count=%0d empty=%b full=%b rd_valid=%b exp 0/1/0/0", count0, empty0, full0, rd_valid0); end
    endtask

    task automatic test_drain();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                checks++; if (rd_data !== 16'(i)) begin errors++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, rd_data, 16'(i)); end
            end
            step(0, 0, 1, 0);
            checks++; if (count !== 6'(m_q.size())) begin errors++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, count, m_q.size()); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", empty); end
        checks++; if (underflow_err !== 1'b1) begin errors++; $display("FAIL drain_underflow got=%b exp=1", underflow_err); end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL drain_overflow got=%b exp=0", overflow_err); end
        rd_ready = 0;
    endtask

    task automatic test_preload0();
        do_reset();
        rr0 = 1;
        #1;
        checks++; if (rd_valid0 !== 1'b0) begin errors++; $display("FAIL p0_before got=%b exp=0", rd_valid0); end
        wv0 = 1; wd0 = 16'hA5A5;
        @(posedge clk); #1;
        wv0 = 0;
        checks++; if ({rd_valid0, rd_data0, count0} !== {1'b1, 16'hA5A5, 6'd1}) begin errors++; $display("FAIL p0_after valid=%b data=%h count=%0d exp 1/a5a5/1", rd_valid0, rd_data0, count0); end
        @(posedge clk); #1;
        checks++; if ({rd_valid0, count0} !== {1'b0, 6'd0}) begin errors++; $display("FAIL p0_popped valid=%b count=%0d exp 0/0", rd_valid0, count0); end
        rr0 = 0;
    endtask

    task automatic test_fill_and_async_reset();
        do_reset();
        for (int i = 0; i < 28; i++) step(1, 16'($urandom), 0, 0);
        checks++; if ({full, wr_ready, count} !== {2'b10, 6'd32}) begin errors++; $display("FAIL fill full=%b wr_ready=%b count=%0d exp 1/0/32", full, wr_ready, count); end
        checks++; if (rd_data !== m_q[0]) begin errors++; $display("FAIL fill_head got=%h exp=%h", rd_data, m_q[0]); end
        step(1, 16'hBEEF, 1, 0);
        checks++; if ({overflow_err, count} !== {1'b1, 6'd31}) begin errors++; $display("FAIL fill_overflow ovf=%b count=%0d exp 1/31", overflow_err, count); end
        checks++; if (rd_data !== m_q[0]) begin errors++; $display("FAIL fill_after_head got=%h exp=%h", rd_data, m_q[0]); end
        for (int i = 0; i < 14; i++) step(0, 0, 1, 0);
        checks++; if (count !== 6'd17) begin errors++; $display("FAIL pre_async count got=%0d exp=17", count); end
        #2;
        reset = 1;
        model_reset();
        #1;
        checks++; if ({count, rd_data} !== {6'd4, 16'd0}) begin errors++; $display("FAIL async_reset count=%0d data=%h exp 4/0", count, rd_data); end
        checks++; if ({overflow_err, underflow_err} !== 2'b00) begin errors++; $display("FAIL async_reset_flags got=%b exp=00", {overflow_err, underflow_err}); end
        wr_valid = 0; rd_ready = 0;
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 100; i++) begin
            step(1, 16'(16'h1000 + i), 1, 0);
            checks++; if (count !== 6'd4) begin errors++; $display("FAIL b2b_count[%0d] got=%0d exp=4", i, count); end
            checks++; if (rd_data !== m_q[0]) begin errors++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, rd_data, m_q[0]); end
        end
        wr_valid = 0; rd_ready = 0;
    endtask

    task automatic test_clear_err();
        do_reset();
        for (int i = 0; i < 28; i++) step(1, 16'(i), 0, 0);
        step(1, 0, 0, 0);
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL clr_set got=%b exp=1", overflow_err); end
        step(1, 0, 0, 1);
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL clr_set_wins got=%b exp=1", overflow_err); end
        step(0, 0, 0, 1);
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL clr_alone got=%b exp=0", overflow_err); end
        checks++; if (count !== 6'd32) begin errors++; $display("FAIL clr_count got=%0d exp=32", count); end
        clear_err = 0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            // bias toward writes in the first half and reads in the second to hit both boundaries
            step(($urandom_range(0, 99) < (i < 300 ? 70 : 30)), 16'($urandom),
                 ($urandom_range(0, 99) < (i < 300 ? 30 : 70)), ($urandom_range(0, 19) == 0));
            checks++;
            if (count !== 6'(m_q.size()) || full !== (m_q.size() == DEPTH) || empty !== (m_q.size() == 0)
                || wr_ready !== (m_q.size() != DEPTH) || rd_valid !== (m_q.size() != 0)
                || overflow_err !== m_ovf || underflow_err !== m_udf) begin
                errors++;
                $display("FAIL rand_status[%0d] count=%0d exp=%0d ovf=%b exp=%b udf=%b exp=%b full=%b empty=%b",
                         i, count, m_q.size(), overflow_err, m_ovf, underflow_err, m_udf, full, empty);
            end
            if (m_q.size() != 0) begin
                checks++; if (rd_data !== m_q[0]) begin errors++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, rd_data, m_q[0]); end
            end
        end
        wr_valid = 0; rd_ready = 0; clear_err = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_drain();
        test_preload0();
        test_fill_and_async_reset();
        test_back_to_back();
        test_clear_err();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/kpn_fifo_channel.md
Name: kpn_fifo_channel

Overview:
- Parametrised KPN channel FIFO that carries tokens between two process modules.
- Supersedes the fixed 16-bit, 32-entry, read-only precharged queue. Adds:
  - a producer-side valid/ready write port
  - a consumer-side valid/ready read port
  - a configurable reset-time preload of initial tokens
  - an occupancy count
  - sticky overflow and underflow flags
- Blocking-read/blocking-write semantics are enforced by the handshakes, not by the processes.

Parameters:
DATA_WIDTH, 16, token width in bits
ADDR_WIDTH, 5, pointer width; DEPTH = 2**ADDR_WIDTH entries
PRELOAD_COUNT, 4, tokens present after reset; legal range 0..DEPTH
PRELOAD_BASE, 0, value of preloaded token 0
PRELOAD_STEP, 1, preloaded token k = PRELOAD_BASE + k*PRELOAD_STEP, truncated to DATA_WIDTH

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
wr_valid  input  1  producer offers wr_data
wr_data  input  DATA_WIDTH  token to write
wr_ready  output  1  space available; equals !full
rd_valid  output  1  token available; equals !empty
rd_data  output  DATA_WIDTH  head token (first-word fall-through)
rd_ready  input  1  consumer takes head token
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
overflow_err  output  1  sticky: write attempted while full
underflow_err  output  1  sticky: read attempted while empty
clear_err  input  1  synchronous clear of both sticky flags

Behaviour:
- Reset (asynchronous assert, released synchronously by the clock domain):
  - r_ptr = 0; w_ptr = PRELOAD_COUNT mod DEPTH; count = PRELOAD_COUNT.
  - mem[k] = PRELOAD_BASE + k*PRELOAD_STEP for k < PRELOAD_COUNT; mem[k] = 0 otherwise.
  - overflow_err = 0, underflow_err = 0.
  - Resulting outputs: full = (PRELOAD_COUNT == DEPTH), empty = (PRELOAD_COUNT == 0), rd_data = mem[0].
- Reset mid-operation: all in-flight contents are discarded and the preload state is restored. The handshake inputs are ignored while reset is high.
- Write accept: wr_valid && !full at a rising edge. wr_data is stored at mem[w_ptr]; w_ptr increments modulo DEPTH.
- Read accept: rd_ready && !empty at a rising edge. r_ptr increments modulo DEPTH.
- rd_data = mem[r_ptr] combinationally. It is valid only while rd_valid = 1 and holds the stale slot value when empty.
- Latency: a token written at edge N appears on rd_data/rd_valid after edge N. There is no same-cycle bypass when empty.
- Simultaneous accepted read and write: count is unchanged and both pointers advance.
- When full, wr_ready = 0 even if rd_ready = 1 in the same cycle. There is no full-pass-through.
- count update: +1 on write only, -1 on read only, unchanged otherwise. full and empty are derived from count, never from pointer equality.
- Pointer wrap: both pointers roll from DEPTH-1 to 0 with no gap or duplicated entry.
- overflow_err sets on an edge with wr_valid && full. underflow_err sets on an edge with rd_ready && empty.
- Rejected operations change no state other than the error flags.
- clear_err clears both flags at the edge. If a new error event occurs at the same edge, set wins.
- No internal state machine beyond the pointers and count. There are no combinational paths from wr_* to rd_* or from rd_* to wr_*.

Test Plan:
- Defaults, reset then rd_ready=1 for 5 cycles -> rd_data 0,1,2,3 accepted; count 4→0; empty=1 after the 4th read; 5th cycle sets underflow_err=1.
- PRELOAD_COUNT=0; write 0xA5A5 at edge N, rd_ready held high -> rd_valid=0 before N, rd_valid=1 with rd_data=0xA5A5 after N; popped at N+1; count 0→1→0.
- Fill from 4 with 28 writes -> full=1, count=32, wr_ready=0. A 29th write with rd_ready=1 at the same edge -> write rejected, read accepted, overflow_err=1, count=31.
- Continuous simultaneous read/write for 100 cycles with an incrementing wr_data pattern -> count constant at 4; read order matches write order across ≥3 pointer wraps.
- Assert reset asynchronously mid-stream (count=17) -> on assertion, before any clock edge, count=4, rd_data=0, error flags 0.
- Set overflow_err, then pulse clear_err with wr_valid&&full in the same cycle -> flag stays 1. Pulse clear_err alone -> flag 0.
